// File: rtl/vga_scanout_pkg.sv
// Shared VGA definitions: pixel/framebuffer geometry, default 640x480 timing,
// the per-stage raster flag bundle and a clog2 helper for port widths.
package vga_scanout_pkg;

  localparam int PIXEL_SIZE_DEF = 8;
  localparam int WIDTH          = 160;
  localparam int HEIGHT         = 120;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Raster flags produced at the counter stage and carried down the delay line
  typedef struct packed {
    logic vis;
    logic hs_act;
    logic vs_act;
    logic in_fb;
  } raster_flags_t;

  // Bits needed to hold 0..value-1, never less than 1 so ports stay legal
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/vga_scanout_axis_counter.sv
// One raster axis: position counter with wrap, active/sync decode and a
// replication sub-counter that walks the framebuffer index without a divider.
module vga_axis_counter
  import vga_scanout_pkg::*;
#(
  parameter int ACTIVE  = H_ACTIVE_DEF,
  parameter int FP      = H_FP_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BP      = H_BP_DEF,
  parameter int SCALE   = 4,
  parameter int FB_SIZE = WIDTH,
  parameter int CW      = clog2(ACTIVE + FP + SYNC + BP + 1),
  parameter int IW      = clog2(FB_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          vis,
  output logic          sync_act,
  output logic [IW-1:0] fb_idx,
  output logic          in_fb
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int SW    = clog2(SCALE);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(FB_SIZE - 1);

  logic [SW-1:0] sub;

  assign wrap     = ce && (cnt == LAST);
  assign vis      = (cnt < ACT_END);
  assign sync_act = (cnt >= SYNC_START) && (cnt < SYNC_END);

  // Position, replication phase and framebuffer index; all restart on wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sub    <= '0;
      fb_idx <= '0;
      in_fb  <= 1'b1;
    end else if (ce) begin
      if (cnt == LAST) begin
        cnt    <= '0;
        sub    <= '0;
        fb_idx <= '0;
        in_fb  <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
        if (sub == SUB_LAST) begin
          sub <= '0;
          // Index sticks at the last entry; stepping past it leaves the image
          if (fb_idx == IDX_LAST) begin
            in_fb <= 1'b0;
          end else begin
            fb_idx <= fb_idx + IW'(1);
          end
        end else begin
          sub <= sub + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing from clk gated by pix_ce, framebuffer address
// generation, read-latency matching of the timing flags, registered pins and
// a frame_done strobe at the start of vertical blanking.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int                  H_ACTIVE   = H_ACTIVE_DEF,
  parameter int                  H_FP       = H_FP_DEF,
  parameter int                  H_SYNC     = H_SYNC_DEF,
  parameter int                  H_BP       = H_BP_DEF,
  parameter int                  V_ACTIVE   = V_ACTIVE_DEF,
  parameter int                  V_FP       = V_FP_DEF,
  parameter int                  V_SYNC     = V_SYNC_DEF,
  parameter int                  V_BP       = V_BP_DEF,
  parameter bit                  SYNC_POL   = 1'b0,
  parameter int                  PIXEL_SIZE = PIXEL_SIZE_DEF,
  parameter int                  FB_WIDTH   = WIDTH,
  parameter int                  FB_HEIGHT  = HEIGHT,
  parameter int                  SCALE      = 4,
  parameter int                  RD_LAT     = 1,
  parameter logic [PIXEL_SIZE-1:0] BORDER   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pix_ce,
  output logic [clog2(FB_WIDTH)-1:0]   fb_col,
  output logic [clog2(FB_HEIGHT)-1:0]  fb_row,
  input  logic [PIXEL_SIZE-1:0]        fb_pixel,
  output logic [PIXEL_SIZE-1:0]        rgb,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         de,
  output logic                         frame_done
);

  localparam int HCW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);
  localparam int VCW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1);
  localparam int CIW = clog2(FB_WIDTH);
  localparam int RIW = clog2(FB_HEIGHT);

  localparam logic [VCW-1:0] V_LAST_ACT = VCW'(V_ACTIVE - 1);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_wrap, v_wrap;
  logic           h_vis, v_vis, h_sync, v_sync, h_in, v_in;

  raster_flags_t  cur, dly;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .SCALE(SCALE), .FB_SIZE(FB_WIDTH), .CW(HCW), .IW(CIW)
  ) u_h (
    .clk(clk), .reset(reset), .ce(pix_ce),
    .cnt(h_cnt), .wrap(h_wrap), .vis(h_vis), .sync_act(h_sync),
    .fb_idx(fb_col), .in_fb(h_in)
  );

  // The vertical axis steps once per completed line
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .SCALE(SCALE), .FB_SIZE(FB_HEIGHT), .CW(VCW), .IW(RIW)
  ) u_v (
    .clk(clk), .reset(reset), .ce(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .vis(v_vis), .sync_act(v_sync),
    .fb_idx(fb_row), .in_fb(v_in)
  );

  // Frame wrap and raw h position are not needed beyond the counters
  logic unused_ok;
  assign unused_ok = &{1'b0, v_wrap, h_cnt};

  assign cur = '{vis: h_vis & v_vis, hs_act: h_sync, vs_act: v_sync,
                 in_fb: h_in & v_in};

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign dly = cur;
    end else begin : g_lat
      raster_flags_t pipe [RD_LAT];
      // Hold the flags back until the matching pixel arrives from the framebuffer
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else if (pix_ce) begin
          pipe[0] <= cur;
          for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign dly = pipe[RD_LAT-1];
    end
  endgenerate

  // Pin registers: aligned sync/de/rgb, holding between pixel beats
  always_ff @(posedge clk) begin
    if (reset) begin
      de    <= 1'b0;
      rgb   <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else if (pix_ce) begin
      de    <= dly.vis;
      rgb   <= dly.vis ? (dly.in_fb ? fb_pixel : BORDER) : '0;
      hsync <= dly.hs_act ? SYNC_POL : ~SYNC_POL;
      vsync <= dly.vs_act ? SYNC_POL : ~SYNC_POL;
    end
  end

  // One-clk strobe as the raster enters vertical blanking (swap is safe)
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= h_wrap && (v_cnt == V_LAST_ACT);
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a tiny raster (15x8 total, 8x4 visible, SCALE 2).
// DUT a: 4x2 framebuffer; DUT b: 3x2 framebuffer with border 8'hA5.
module tb_vga_scanout;

  localparam int HT = 15;
  localparam int FT = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_ce = 1'b1;

  logic [1:0] fb_col_a, fb_col_b;
  logic [0:0] fb_row_a, fb_row_b;
  logic [7:0] fb_pixel_a = '0, fb_pixel_b = '0;
  logic [7:0] rgb_a, rgb_b;
  logic       hsync_a, vsync_a, de_a, fd_a;
  logic       hsync_b, vsync_b, de_b, fd_b;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .PIXEL_SIZE(8), .FB_WIDTH(4), .FB_HEIGHT(2),
    .SCALE(2), .RD_LAT(1), .BORDER(8'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .fb_col(fb_col_a), .fb_row(fb_row_a), .fb_pixel(fb_pixel_a),
    .rgb(rgb_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .frame_done(fd_a)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .PIXEL_SIZE(8), .FB_WIDTH(3), .FB_HEIGHT(2),
    .SCALE(2), .RD_LAT(1), .BORDER(8'hA5)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .fb_col(fb_col_b), .fb_row(fb_row_b), .fb_pixel(fb_pixel_b),
    .rgb(rgb_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .frame_done(fd_b)
  );

  function automatic logic [7:0] pix_of(input int row, input int col);
    return 8'((row * 16) + col);
  endfunction

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Framebuffers: content {row,col}, one pix_ce beat of read latency
  always @(posedge clk) begin
    if (pix_ce) begin
      fb_pixel_a <= pix_of(int'(fb_row_a), int'(fb_col_a));
      fb_pixel_b <= pix_of(int'(fb_row_b), int'(fb_col_b));
    end
  end

  // ---------------- reference model state ----------------
  // k = pixel beats since the last reset edge; the raster sits at position k
  // and the pins show position k-2.
  int k = 0;
  bit last_ce = 1'b0;
  bit started = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      k = 0;
      last_ce = 1'b0;
      started = 1'b1;
    end else begin
      last_ce = pix_ce;
      if (pix_ce) k = k + 1;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int fbw, input int border,
                           input int de, input int rgb, input int hs,
                           input int vs, input int fd, input int col,
                           input int row);
    int p, pos, h, v, e_de, e_rgb, e_hs, e_vs, e_fd, e_col, e_row;
    p = k - 2;
    if (p < 0) begin
      e_de = 0; e_rgb = 0; e_hs = 1; e_vs = 1;
    end else begin
      pos  = p % FT;
      h    = pos % HT;
      v    = pos / HT;
      e_de = (h < 8 && v < 4) ? 1 : 0;
      e_hs = (h >= 10 && h < 13) ? 0 : 1;
      e_vs = (v >= 5 && v < 7) ? 0 : 1;
      if (e_de == 0)                   e_rgb = 0;
      else if (h / 2 < fbw && v / 2 < 2) e_rgb = int'(pix_of(v / 2, h / 2));
      else                             e_rgb = border;
    end
    e_fd  = (last_ce && (k % FT == 60)) ? 1 : 0;
    e_col = imin((k % HT) / 2, fbw - 1);
    e_row = imin(((k % FT) / HT) / 2, 1);
    cmp($sformatf("%s.de", tag), de, e_de);
    cmp($sformatf("%s.rgb", tag), rgb, e_rgb);
    cmp($sformatf("%s.hsync", tag), hs, e_hs);
    cmp($sformatf("%s.vsync", tag), vs, e_vs);
    cmp($sformatf("%s.frame_done", tag), fd, e_fd);
    cmp($sformatf("%s.fb_col", tag), col, e_col);
    cmp($sformatf("%s.fb_row", tag), row, e_row);
  endtask

  // ---------------- scoreboard: every cycle, away from the active edge ----------------
  always @(negedge clk) begin
    if (started) begin
      check_dut("a", 4, 0, int'(de_a), int'(rgb_a), int'(hsync_a), int'(vsync_a),
                int'(fd_a), int'(fb_col_a), int'(fb_row_a));
      check_dut("b", 3, 'hA5, int'(de_b), int'(rgb_b), int'(hsync_b), int'(vsync_b),
                int'(fd_b), int'(fb_col_b), int'(fb_row_b));
    end
  end

  // frame_done period, restarted whenever the stimulus changes regime
  int fd_epoch = 0;
  int fd_period = FT;
  int seen_epoch = -1;
  int last_fd = -1;

  always @(negedge clk) begin
    if (fd_a) begin
      if (seen_epoch == fd_epoch && last_fd >= 0)
        cmp("frame_done_period", cyc - last_fd, fd_period);
      seen_epoch = fd_epoch;
      last_fd = cyc;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    pix_ce = 1'b1;
    step(3);
    reset = 1'b0;                                  // k = 0

    step(2);                                       // k = 2: pixel (0,0) on pins
    cmp("lit_first_de", int'(de_a), 1);
    cmp("lit_first_rgb", int'(rgb_a), 'h00);
    step(2);                                       // k = 4: h=2 -> col 1
    cmp("lit_rgb_col1", int'(rgb_a), 'h01);
    step(6);                                       // k = 10: h=8 blank
    cmp("lit_de_blank", int'(de_a), 0);
    cmp("lit_rgb_blank", int'(rgb_a), 0);
    step(4);                                       // k = 14: h=12 in hsync
    cmp("lit_hsync_low", int'(hsync_a), 0);
    step(1);                                       // k = 15: h=13 sync over
    cmp("lit_hsync_end", int'(hsync_a), 1);
    step(17);                                      // k = 32: line 2, h=0 -> row 1
    cmp("lit_rgb_row1", int'(rgb_a), 'h10);
    step(6);                                       // k = 38: line 2, h=6
    cmp("lit_rgb_col3", int'(rgb_a), 'h13);
    cmp("lit_border", int'(rgb_b), 'hA5);
    cmp("lit_col_sat", int'(fb_col_b), 2);
    step(22);                                      // k = 60: raster at (0,4)
    cmp("lit_frame_done", int'(fd_a), 1);
    step(1);
    cmp("lit_frame_done_1clk", int'(fd_a), 0);

    step(2 * FT);

    // pixel clock enable at half rate
    fd_epoch = fd_epoch + 1;
    fd_period = 2 * FT;
    for (int i = 0; i < 5 * FT; i++) begin
      pix_ce = (i % 2 == 0);
      step(1);
    end
    pix_ce = 1'b1;
    fd_epoch = fd_epoch + 1;
    fd_period = FT;

    // reach line 2, h=5 then reset for one clk
    for (int i = 0; i < 300 && (k % FT) != 35; i++) step(1);
    cmp("reach_line2", k % FT, 35);
    reset = 1'b1;
    fd_epoch = fd_epoch + 1;
    step(1);
    cmp("lit_rst_hsync", int'(hsync_a), 1);
    cmp("lit_rst_vsync", int'(vsync_a), 1);
    cmp("lit_rst_de", int'(de_a), 0);
    cmp("lit_rst_rgb", int'(rgb_a), 0);
    reset = 1'b0;
    step(2);
    cmp("lit_restart_de", int'(de_a), 1);
    cmp("lit_restart_rgb", int'(rgb_a), 'h00);
    step(3 * FT);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
